issueq_int: RTL and testbench

//  Integer issue queue: the producer side of the integer handshake that the issue unit consumes.
//  - Holds dispatched integer ops and snoops the CDB for source-operand tags.
//  - Presents the oldest op with both operands ready on issueint_*.
//  - Drops the op when the issue unit returns issueint_equeueint_done.

---
 rtl/issueq_int.sv | 165 ++++++++++++++++
 tb/tb_issueq_int.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/issueq_int.sv
// Integer issue queue: compacting array of dispatched ops with CDB wakeup and oldest-ready select.
// Optional feature macro: ISSUEQ_BRANCH_FLUSH_EN (taken branch on the CDB empties the queue).
module issueq_int #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_en,
    input  logic [OPC_W-1:0]           disp_opcode,
    input  logic [DATA_W-1:0]          disp_rsdata,
    input  logic [DATA_W-1:0]          disp_rtdata,
    input  logic [TAG_W-1:0]           disp_rstag,
    input  logic [TAG_W-1:0]           disp_rttag,
    input  logic                       disp_rsvalid,
    input  logic                       disp_rtvalid,
    input  logic [TAG_W-1:0]           disp_rdtag,
    output logic                       issueq_full,
    output logic [$clog2(DEPTH):0]     issueq_count,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tagout,
    input  logic [DATA_W-1:0]          cdb_out,
    input  logic                       cdb_branch,
    input  logic                       cdb_branch_taken,
    output logic                       issueint_ready,
    output logic [OPC_W-1:0]           issueint_opcode,
    output logic [DATA_W-1:0]          issueint_rsdata,
    output logic [DATA_W-1:0]          issueint_rtdata,
    output logic [TAG_W-1:0]           issueint_rdtag,
    input  logic                       issueint_equeueint_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic              valid;
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] rs_data;
        logic [TAG_W-1:0]  rs_tag;
        logic              rs_rdy;
        logic [DATA_W-1:0] rt_data;
        logic [TAG_W-1:0]  rt_tag;
        logic              rt_rdy;
        logic [TAG_W-1:0]  rd_tag;
    } entry_t;

    entry_t           q      [DEPTH];
    entry_t           q_nxt  [DEPTH];
    entry_t           q_ext  [DEPTH+1];
    entry_t           new_entry;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             flush;
    logic             remove;
    logic             accept;
    logic             snoop_rs;
    logic             snoop_rt;

`ifdef ISSUEQ_BRANCH_FLUSH_EN
    assign flush = cdb_valid & cdb_branch & cdb_branch_taken;
`else
    assign flush = 1'b0;
    wire unused_branch = &{1'b0, cdb_branch, cdb_branch_taken};
`endif

    // Capture a CDB broadcast into any operand still waiting on that tag.
    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        if (cdb_valid && e.valid && !e.rs_rdy && e.rs_tag == cdb_tagout) begin
            r.rs_data = cdb_out;
            r.rs_rdy  = 1'b1;
        end
        if (cdb_valid && e.valid && !e.rt_rdy && e.rt_tag == cdb_tagout) begin
            r.rt_data = cdb_out;
            r.rt_rdy  = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rs_rdy && q[i].rt_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issueint_ready  = sel_found;
    assign issueint_opcode = sel_found ? q[sel_idx].opcode  : '0;
    assign issueint_rsdata = sel_found ? q[sel_idx].rs_data : '0;
    assign issueint_rtdata = sel_found ? q[sel_idx].rt_data : '0;
    assign issueint_rdtag  = sel_found ? q[sel_idx].rd_tag  : '0;

    assign issueq_full  = (count_q == CNT_W'(DEPTH));
    assign issueq_count = count_q;
    assign remove       = issueint_equeueint_done & sel_found & ~flush;
    assign accept       = disp_en & ~issueq_full & ~flush;
    assign snoop_rs     = cdb_valid & ~disp_rsvalid & (cdb_tagout == disp_rstag);
    assign snoop_rt     = cdb_valid & ~disp_rtvalid & (cdb_tagout == disp_rttag);
    assign wr_idx       = count_q - CNT_W'(remove);

    always_comb begin
        new_entry         = '0;
        new_entry.valid   = 1'b1;
        new_entry.opcode  = disp_opcode;
        new_entry.rs_tag  = disp_rstag;
        new_entry.rt_tag  = disp_rttag;
        new_entry.rd_tag  = disp_rdtag;
        new_entry.rs_rdy  = disp_rsvalid | snoop_rs;
        new_entry.rt_rdy  = disp_rtvalid | snoop_rt;
        new_entry.rs_data = disp_rsvalid ? disp_rsdata : (snoop_rs ? cdb_out : '0);
        new_entry.rt_data = disp_rtvalid ? disp_rtdata : (snoop_rt ? cdb_out : '0);
    end

    // Entries at or above the removed slot pull from the next index; q_ext pads the top with an empty slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_ext[i] = q[i];
        end
        q_ext[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = '0;
            if (!flush) begin
                if (remove && i >= int'(sel_idx)) begin
                    q_nxt[i] = wake(q_ext[i+1]);
                end else begin
                    q_nxt[i] = wake(q_ext[i]);
                end
                if (accept && CNT_W'(i) == wr_idx) begin
                    q_nxt[i] = new_entry;
                end
            end
        end
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count_q + CNT_W'(accept) - CNT_W'(remove);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            count_q <= count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_issueq_int.sv
// Self-checking bench for issueq_int: expected issue packets queued at dispatch/wakeup, compared at issue.
module tb_issueq_int;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_en;
    logic [5:0]  disp_opcode;
    logic [31:0] disp_rsdata, disp_rtdata;
    logic [5:0]  disp_rstag, disp_rttag, disp_rdtag;
    logic        disp_rsvalid, disp_rtvalid;
    logic        issueq_full;
    logic [3:0]  issueq_count;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        cdb_branch, cdb_branch_taken;
    logic        issueint_ready;
    logic [5:0]  issueint_opcode;
    logic [31:0] issueint_rsdata, issueint_rtdata;
    logic [5:0]  issueint_rdtag;
    logic        issueint_equeueint_done;

    logic [75:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    issueq_int dut (
        .clk(clk), .reset(reset),
        .disp_en(disp_en), .disp_opcode(disp_opcode),
        .disp_rsdata(disp_rsdata), .disp_rtdata(disp_rtdata),
        .disp_rstag(disp_rstag), .disp_rttag(disp_rttag),
        .disp_rsvalid(disp_rsvalid), .disp_rtvalid(disp_rtvalid),
        .disp_rdtag(disp_rdtag),
        .issueq_full(issueq_full), .issueq_count(issueq_count),
        .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
        .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
        .issueint_ready(issueint_ready), .issueint_opcode(issueint_opcode),
        .issueint_rsdata(issueint_rsdata), .issueint_rtdata(issueint_rtdata),
        .issueint_rdtag(issueint_rdtag),
        .issueint_equeueint_done(issueint_equeueint_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [75:0] pack(input logic [5:0] o, input logic [31:0] s,
                                         input logic [31:0] t, input logic [5:0] d);
        return {o, s, t, d};
    endfunction

    task automatic clear_in();
        disp_en = 1'b0;
        cdb_valid = 1'b0;
        cdb_branch = 1'b0;
        cdb_branch_taken = 1'b0;
        issueint_equeueint_done = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        step();
        clear_in();
    endtask

    task automatic set_disp(input logic [5:0] opc, input logic [31:0] rs_d, input logic rs_v,
                            input logic [5:0] rs_t, input logic [31:0] rt_d, input logic rt_v,
                            input logic [5:0] rt_t, input logic [5:0] rd);
        disp_en = 1'b1;
        disp_opcode = opc;
        disp_rsdata = rs_d;
        disp_rsvalid = rs_v;
        disp_rstag = rs_t;
        disp_rtdata = rt_d;
        disp_rtvalid = rt_v;
        disp_rttag = rt_t;
        disp_rdtag = rd;
    endtask

    task automatic set_cdb(input logic [5:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tagout = t;
        cdb_out = v;
    endtask

    // Waits (bounded) for an issuable op, compares it with the scoreboard head, then accepts it.
    task automatic expect_issue(input string tag);
        logic [75:0] exp;
        int waited;
        waited = 0;
        while (!issueint_ready && waited < 10) begin
            step();
            waited++;
        end
        check({tag, "_ready"}, 128'(issueint_ready), 128'(1));
        if (!issueint_ready) begin
            clear_in();
            return;
        end
        check({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() == 0) begin
            clear_in();
            return;
        end
        exp = exp_q.pop_front();
        check(tag, {issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag}, 128'(exp));
        issueint_equeueint_done = 1'b1;
        cycle();
    endtask

    initial begin
        reset = 1'b0;
        disp_opcode = '0; disp_rsdata = '0; disp_rtdata = '0;
        disp_rstag = '0; disp_rttag = '0; disp_rdtag = '0;
        disp_rsvalid = 1'b0; disp_rtvalid = 1'b0;
        cdb_tagout = '0; cdb_out = '0;
        clear_in();
        repeat (2) step();
        check("rst_count", 128'(issueq_count), 128'(0));
        check("rst_full", 128'(issueq_full), 128'(0));
        check("rst_ready", 128'(issueint_ready), 128'(0));
        reset = 1'b1;
        cycle();

        // Ready-at-dispatch op issues the next cycle.
        set_disp(6'h20, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd3);
        exp_q.push_back(pack(6'h20, 32'd5, 32'd7, 6'd3));
        cycle();
        check("t2_count", 128'(issueq_count), 128'(1));
        expect_issue("t2_issue");
        check("t2_count_after", 128'(issueq_count), 128'(0));
        check("t2_ready_after", 128'(issueint_ready), 128'(0));
        check("t2_opcode_zero", 128'(issueint_opcode), 128'(0));

        // CDB wakeup: issuable only the cycle after the broadcast.
        set_disp(6'h11, 32'd0, 1'b0, 6'd9, 32'd1, 1'b1, 6'd0, 6'd4);
        cycle();
        check("t3_wait", 128'(issueint_ready), 128'(0));
        set_cdb(6'd9, 32'hDEAD);
        check("t3_same_cycle", 128'(issueint_ready), 128'(0));
        exp_q.push_back(pack(6'h11, 32'hDEAD, 32'd1, 6'd4));
        cycle();
        expect_issue("t3_issue");

        // Dispatch snoop, then dispatch+remove in one cycle.
        set_disp(6'h12, 32'd0, 1'b0, 6'd12, 32'd2, 1'b1, 6'd0, 6'd5);
        set_cdb(6'd12, 32'd44);
        exp_q.push_back(pack(6'h12, 32'd44, 32'd2, 6'd5));
        cycle();
        check("t4_count", 128'(issueq_count), 128'(1));
        set_disp(6'h13, 32'd8, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 6'd6);
        exp_q.push_back(pack(6'h13, 32'd8, 32'd9, 6'd6));
        expect_issue("t4_snoop_issue");
        check("t4_count_same", 128'(issueq_count), 128'(1));
        expect_issue("t4_new_issue");
        check("t4_count_empty", 128'(issueq_count), 128'(0));

        // Fill, dropped dispatch while full, oldest-first select, wakeup during shift.
        for (int i = 0; i < 8; i++) begin
            set_disp(6'(6'h30 + i), (i == 0) ? 32'd100 : 32'd0, (i == 0), 6'(20 + i),
                     32'(200 + i), 1'b1, 6'd0, 6'(40 + i));
            cycle();
        end
        exp_q.push_back(pack(6'h30, 32'd100, 32'd200, 6'd40));
        check("t5_full", 128'(issueq_full), 128'(1));
        check("t5_count8", 128'(issueq_count), 128'(8));
        set_disp(6'h3f, 32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd63);
        expect_issue("t5_oldest");
        check("t5_dropped_count", 128'(issueq_count), 128'(7));
        check("t5_not_full", 128'(issueq_full), 128'(0));
        check("t5_none_ready", 128'(issueint_ready), 128'(0));
        set_cdb(6'd24, 32'h444);
        cycle();
        set_cdb(6'd21, 32'h111);
        cycle();
        exp_q.push_back(pack(6'h31, 32'h111, 32'd201, 6'd41));
        exp_q.push_back(pack(6'h34, 32'h444, 32'd204, 6'd44));
        exp_q.push_back(pack(6'h35, 32'h555, 32'd205, 6'd45));
        set_cdb(6'd25, 32'h555);
        expect_issue("t5_first_of_two");
        check("t5_count6", 128'(issueq_count), 128'(6));
        expect_issue("t5_second");
        expect_issue("t5_shift_wake");
        check("t5_count4", 128'(issueq_count), 128'(4));
        check("t5_idle", 128'(issueint_ready), 128'(0));

        // Asynchronous reset mid-operation with 5 entries, one of them ready.
        set_disp(6'h3e, 32'd3, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 6'd62);
        cycle();
        check("t1_count5", 128'(issueq_count), 128'(5));
        check("t1_ready_pre", 128'(issueint_ready), 128'(1));
        reset = 1'b0;
        #1;
        check("t1_count", 128'(issueq_count), 128'(0));
        check("t1_ready", 128'(issueint_ready), 128'(0));
        check("t1_fields", {issueint_opcode, issueint_rsdata, issueint_rtdata, issueint_rdtag}, 128'(0));
        exp_q.delete();
        reset = 1'b1;
        cycle();

        // Taken branch on the CDB.
        for (int i = 0; i < 3; i++) begin
            set_disp(6'(6'h01 + i), 32'd0, 1'b0, 6'(50 + i), 32'd0, 1'b1, 6'd0, 6'(i));
            cycle();
        end
        check("t6_count3", 128'(issueq_count), 128'(3));
        set_cdb(6'd63, 32'd0);
        cdb_branch = 1'b1;
        cdb_branch_taken = 1'b1;
        cycle();
`ifdef ISSUEQ_BRANCH_FLUSH_EN
        check("t6_flush", 128'(issueq_count), 128'(0));
`else
        check("t6_no_flush", 128'(issueq_count), 128'(3));
`endif
        check("t6_sb_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
